mc_lsu: RTL
===========

MC_LSU -- requirements
Module: mc_lsu

Interface
REQ-001 Parameters SHALL be: DMEM_WORDS, default 2048, data-memory depth in 32-bit words (power of 2).
REQ-002 MEM_LAT, default 1, range 1..4, data-memory read latency in cycles.
REQ-003 NUM_HEX, default 8, number of 7-segment digits.
REQ-004 LEDR_W, default 17, and LEDG_W, default 8: LED port widths.
REQ-005 Ports SHALL be: i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_req  in  1  access request; accepted when i_req & o_ready.
REQ-008 o_ready  out  1  high only in IDLE.
REQ-009 i_addr  in  32  byte address, sampled on accept.
REQ-010 i_wdata  in  32  store data, sampled on accept.
REQ-011 i_we  in  1  1 = store, 0 = load.
REQ-012 i_size  in  2  0 byte, 1 half, 2 word; 3 treated as word.
REQ-013 i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-014 o_done  out  1  one-cycle pulse at access completion.
REQ-015 o_rdata  out  32  load result, valid while o_done high, 0 otherwise.
REQ-016 o_misalign  out  1  pulses with o_done when the access was misaligned.
REQ-017 i_io_sw  in  32  switch inputs.
REQ-018 o_io_ledr  out  LEDR_W;  o_io_ledg  out  LEDG_W;  o_io_lcd  out  32.
REQ-019 o_io_hex  out  NUM_HEX x 7  digit k = bits [8*(k%4)+6 : 8*(k%4)] of hex register k/4.

Function
REQ-020 Address map: 0x0000_0000..4*DMEM_WORDS-1 DMEM; 0x1000_0000 LEDR; 0x1000_1000 LEDG; 0x1000_2000 HEX0-3; 0x1000_3000 HEX4-7; 0x1000_4000 LCD; 0x1001_0000 SW (read-only); bits [11:2] ignored within each IO page.
REQ-021 FSM states: IDLE, RD_WAIT, WRITE, DONE; DONE always returns to IDLE next cycle.
REQ-022 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): IDLE->DONE, o_misalign=1, o_rdata=0, no state changed.
REQ-023 IO or unmapped access: IDLE->DONE (done 1 cycle after accept); IO store writes register in accept cycle; unmapped load returns 0; unmapped or SW store ignored.
REQ-024 DMEM load: IDLE->RD_WAIT for MEM_LAT cycles->DONE; o_done MEM_LAT+1 cycles after accept.
REQ-025 DMEM word store: IDLE->WRITE->DONE; memory updated at end of WRITE; o_done 2 cycles after accept.
REQ-026 DMEM byte/half store: read-modify-write, IDLE->RD_WAIT(MEM_LAT)->WRITE->DONE; only the addressed lanes change; o_done MEM_LAT+2 cycles after accept.
REQ-027 Load extract: byte lane addr[1:0], half lane addr[1]; extended per i_unsigned; IO loads are extracted identically.
REQ-028 i_req while o_ready=0 SHALL be ignored, not queued.
REQ-029 Request, address and data SHALL be latched on accept; input changes afterward have no effect.
REQ-030 Back-to-back: a request asserted in the cycle after o_done is accepted (o_ready=1 in IDLE).
REQ-031 LED/LCD registers are truncated to port width on store; reads return zero-extended values.

Reset
REQ-032 i_rst SHALL force IDLE at the next edge, from any state; an in-flight write is aborted and DMEM is not modified.
REQ-033 During and after reset: o_ready=1, o_done=0, o_misalign=0, o_rdata=0, all LED/HEX/LCD registers 0.
REQ-034 DMEM contents SHALL NOT be reset.

Structure
REQ-035 Package lsu_pkg SHALL hold the state enum, size encoding, and the IO base-address constants.
REQ-036 Sub-module lsu_dmem SHALL implement the word array with a MEM_LAT-deep read pipeline and one write port.
REQ-037 Lane alignment and extension SHALL be combinational logic inside mc_lsu.

Verification
REQ-038 MEM_LAT=2: store word 0xDEADBEEF to 0x40, load word 0x40 -> o_done 2 cycles and 3 cycles after the respective accepts, o_rdata=0xDEADBEEF.
REQ-039 Store byte 0x7F to 0x41 over 0x11223344 -> word reads 0x11227F44; load byte 0x43 signed with 0x80 there -> 0xFFFFFF80, unsigned -> 0x00000080.
REQ-040 Load half at 0x43 -> o_misalign=1, o_rdata=0, memory unchanged; store word to 0x42 -> no write.
REQ-041 Store 0x0000_3F06 to 0x1000_2000 -> o_io_hex[0]=0x06, o_io_hex[1]=0x3F; i_io_sw=0xA5, load 0x1001_0000 -> 0x000000A5 one cycle after accept.
REQ-042 Assert i_rst during WRITE of a byte store -> target word unchanged, o_ready=1 and o_done=0 next cycle.
REQ-043 Pulse i_req during RD_WAIT with a different address -> ignored; only the first access completes.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the multi-cycle load/store unit: FSM states, access sizes, IO map.
package lsu_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Access size encoding (3 behaves as word)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // IO page base addresses; only bits [31:12] select a page
  localparam logic [31:0] IO_LEDR_BASE = 32'h1000_0000;
  localparam logic [31:0] IO_LEDG_BASE = 32'h1000_1000;
  localparam logic [31:0] IO_HEX0_BASE = 32'h1000_2000;
  localparam logic [31:0] IO_HEX1_BASE = 32'h1000_3000;
  localparam logic [31:0] IO_LCD_BASE  = 32'h1000_4000;
  localparam logic [31:0] IO_SW_BASE   = 32'h1001_0000;

  // Half needs addr[0]==0, word needs addr[1:0]==0
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Word-wide data memory: one write port, read data after a LAT-deep register pipeline.
module lsu_dmem #(
  parameter int unsigned WORDS = 2048,
  parameter int unsigned LAT   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(WORDS)-1:0] i_waddr,
  input  logic [31:0]              i_wdata,
  input  logic [$clog2(WORDS)-1:0] i_raddr,
  output logic [31:0]              o_rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] pipe_q [LAT];

  // Single write port; contents are intentionally never reset
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  // Read pipeline: array read enters stage 0, emerges after LAT edges
  always_ff @(posedge i_clk) begin
    pipe_q[0] <= mem[i_raddr];
    for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign o_rdata = pipe_q[LAT-1];

endmodule

// File: rtl/mc_lsu.sv
// Multi-cycle load/store unit: DMEM with read-modify-write sub-word stores plus memory-mapped IO.
module mc_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 2048,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned NUM_HEX    = 8,
  parameter int unsigned LEDR_W     = 17,
  parameter int unsigned LEDG_W     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  output logic                    o_ready,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             i_wdata,
  input  logic                    i_we,
  input  logic [1:0]              i_size,
  input  logic                    i_unsigned,
  output logic                    o_done,
  output logic [31:0]             o_rdata,
  output logic                    o_misalign,
  input  logic [31:0]             i_io_sw,
  output logic [LEDR_W-1:0]       o_io_ledr,
  output logic [LEDG_W-1:0]       o_io_ledg,
  output logic [31:0]             o_io_lcd,
  output logic [NUM_HEX-1:0][6:0] o_io_hex
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  logic [1:0]  state_q, state_n;
  logic [1:0]  cnt_q, cnt_n;
  logic [31:0] addr_q, wdata_q, rdw_q;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic        ready_q, done_q, mis_q;
  logic [31:0] rdata_q, rdata_n;
  logic        mis_n;

  logic [LEDR_W-1:0]  ledr_q;
  logic [LEDG_W-1:0]  ledg_q;
  logic [1:0][31:0]   hex_q;
  logic [31:0]        lcd_q;

  logic        accept_c, mis_c, in_dmem_c;
  logic        hit_ledr_c, hit_ledg_c, hit_hex0_c, hit_hex1_c, hit_lcd_c, hit_sw_c;
  logic [31:0] io_rd_c, io_wr_c, dmem_rdata, dmem_wdata_c;
  logic [AW-1:0] dmem_raddr_c;
  logic        dmem_we_c;

  // Load lane select and sign/zero extension
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lo, 3'b000});
    h = 16'(w >> {lo[1], 4'b0000});
    case (sz)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Store lane placement: replace only the addressed byte/half of the old word
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] lo, input logic [1:0] sz);
    logic [31:0] mask, data;
    case (sz)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {lo, 3'b000};
        data = {24'h0, wd[7:0]} << {lo, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {lo[1], 4'b0000};
        data = {16'h0, wd[15:0]} << {lo[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wd;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  // Request decode on the live inputs (only meaningful in the accept cycle)
  always_comb begin
    accept_c   = i_req & ready_q;
    mis_c      = is_misaligned(i_size, i_addr[1:0]);
    in_dmem_c  = (i_addr[31:AW+2] == '0);
    hit_ledr_c = (i_addr[31:12] == IO_LEDR_BASE[31:12]);
    hit_ledg_c = (i_addr[31:12] == IO_LEDG_BASE[31:12]);
    hit_hex0_c = (i_addr[31:12] == IO_HEX0_BASE[31:12]);
    hit_hex1_c = (i_addr[31:12] == IO_HEX1_BASE[31:12]);
    hit_lcd_c  = (i_addr[31:12] == IO_LCD_BASE[31:12]);
    hit_sw_c   = (i_addr[31:12] == IO_SW_BASE[31:12]);
  end

  // IO read mux (zero-extended registers); unmapped reads as 0
  always_comb begin
    io_rd_c = '0;
    if (hit_ledr_c)      io_rd_c = 32'(ledr_q);
    else if (hit_ledg_c) io_rd_c = 32'(ledg_q);
    else if (hit_hex0_c) io_rd_c = hex_q[0];
    else if (hit_hex1_c) io_rd_c = hex_q[1];
    else if (hit_lcd_c)  io_rd_c = lcd_q;
    else if (hit_sw_c)   io_rd_c = i_io_sw;
    io_wr_c = lane_merge(io_rd_c, i_wdata, i_addr[1:0], i_size);
  end

  // DMEM port hookup: read issued from live address in IDLE so data lines up with RD_WAIT
  always_comb begin
    dmem_raddr_c = ready_q ? i_addr[AW+1:2] : addr_q[AW+1:2];
    dmem_we_c    = (state_q == ST_WRITE) & ~i_rst;
    dmem_wdata_c = lane_merge(rdw_q, wdata_q, addr_q[1:0], size_q);
  end

  lsu_dmem #(
    .WORDS (DMEM_WORDS),
    .LAT   (MEM_LAT)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_we    (dmem_we_c),
    .i_waddr (addr_q[AW+1:2]),
    .i_wdata (dmem_wdata_c),
    .i_raddr (dmem_raddr_c),
    .o_rdata (dmem_rdata)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rdata_n = '0;
    mis_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cnt_n = '0;
          if (mis_c) begin
            state_n = ST_DONE;
            mis_n   = 1'b1;
          end else if (in_dmem_c) begin
            state_n = (i_we && i_size[1]) ? ST_WRITE : ST_RD_WAIT;
          end else begin
            state_n = ST_DONE;
            if (!i_we) rdata_n = lane_extract(io_rd_c, i_addr[1:0], i_size, i_unsigned);
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 2'(MEM_LAT - 1)) begin
          if (we_q) begin
            state_n = ST_WRITE;
          end else begin
            state_n = ST_DONE;
            rdata_n = lane_extract(dmem_rdata, addr_q[1:0], size_q, uns_q);
          end
        end else begin
          cnt_n = cnt_q + 2'd1;
        end
      end
      ST_WRITE: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Registered handshake/result outputs and latched request fields
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
      rdw_q   <= '0;
    end else begin
      ready_q <= (state_n == ST_IDLE);
      done_q  <= (state_n == ST_DONE);
      mis_q   <= mis_n;
      rdata_q <= rdata_n;
      if (accept_c) begin
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        we_q    <= i_we;
        size_q  <= i_size;
        uns_q   <= i_unsigned;
      end
      if (state_q == ST_RD_WAIT) rdw_q <= dmem_rdata;
    end
  end

  // IO registers: written in the accept cycle of an aligned store
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hex_q  <= '0;
      lcd_q  <= '0;
    end else if (accept_c && i_we && !mis_c && !in_dmem_c) begin
      if (hit_ledr_c) ledr_q   <= LEDR_W'(io_wr_c);
      if (hit_ledg_c) ledg_q   <= LEDG_W'(io_wr_c);
      if (hit_hex0_c) hex_q[0] <= io_wr_c;
      if (hit_hex1_c) hex_q[1] <= io_wr_c;
      if (hit_lcd_c)  lcd_q    <= io_wr_c;
    end
  end

  // Digit k takes the low 7 bits of byte k%4 of hex register k/4
  for (genvar k = 0; k < int'(NUM_HEX); k++) begin : g_hex
    if (k < 8) begin : g_map
      assign o_io_hex[k] = hex_q[k/4][8*(k%4) +: 7];
    end else begin : g_none
      assign o_io_hex[k] = '0;
    end
  end

  assign o_ready    = ready_q;
  assign o_done     = done_q;
  assign o_rdata    = rdata_q;
  assign o_misalign = mis_q;
  assign o_io_ledr  = ledr_q;
  assign o_io_ledg  = ledg_q;
  assign o_io_lcd   = lcd_q;

endmodule
